// File: rtl/sync_down_counter_pkg.sv
// Shared constants for the loadable down-counter and its borrow cells.
package sync_down_counter_pkg;
  localparam int SDC_MAX_WIDTH = 16;
endpackage

// File: rtl/sync_down_counter_if.sv
// Control/status bundle of one down-counter stage; master drives controls, slave is the counter.
interface sync_down_counter_if #(
  parameter int WIDTH = 8
);
  logic             cll;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic             ci;
  logic             rld;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             zero;
  logic             co;
  logic             tc;

  modport master (
    output cll, ld, d, ci, rld,
    input  q, qb, zero, co, tc
  );

  modport slave (
    input  cll, ld, d, ci, rld,
    output q, qb, zero, co, tc
  );
endinterface

// File: rtl/sync_down_counter_cell.sv
// One bit of the ripple-borrow down-counter: toggles when every lower bit is zero and borrow-in is high.
module sync_down_counter_cell (
  input  logic clk,
  input  logic rst,
  input  logic cll,
  input  logic ld,
  input  logic d_bit,
  input  logic borrow_in,
  input  logic underflow,
  input  logic rld,
  input  logic r_bit,
  output logic q,
  output logic qb,
  output logic borrow_out
);
  logic q_reg;
  logic q_next;

  // On underflow without reload every borrow is high, so toggling yields all-ones.
  always_comb begin
    q_next = q_reg;
    if (!cll) begin
      q_next = 1'b0;
    end else if (ld) begin
      q_next = d_bit;
    end else if (underflow && rld) begin
      q_next = r_bit;
    end else if (borrow_in) begin
      q_next = ~q_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= 1'b0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q          = q_reg;
  assign qb         = ~q_reg;
  assign borrow_out = borrow_in & ~q_reg;
endmodule

// File: rtl/sync_down_counter.sv
// Loadable down-counter: chain of borrow cells plus reload register, zero detect and terminal-count flop.
module sync_down_counter
  import sync_down_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sync_down_counter_if.slave   bus
);
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_bits;
  logic [WIDTH-1:0] qb_bits;
  logic [WIDTH:0]   borrow;
  logic             zero;
  logic             underflow;
  logic             tc_reg;
  logic             tc_next;

  if (WIDTH < 2 || WIDTH > SDC_MAX_WIDTH) begin : g_bad_width
    $error("sync_down_counter: WIDTH out of range");
  end

  // The borrow leaving the top bit is exactly ci & (q == 0).
  assign borrow[0] = bus.ci;
  assign underflow = borrow[WIDTH];
  assign zero      = ~|q_bits;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    sync_down_counter_cell u_cell (
      .clk        (clk),
      .rst        (rst),
      .cll        (bus.cll),
      .ld         (bus.ld),
      .d_bit      (bus.d[gi]),
      .borrow_in  (borrow[gi]),
      .underflow  (underflow),
      .rld        (bus.rld),
      .r_bit      (r_reg[gi]),
      .q          (q_bits[gi]),
      .qb         (qb_bits[gi]),
      .borrow_out (borrow[gi+1])
    );
  end

  // Clear has priority, so a load under clear leaves the reload value untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg <= '0;
    end else if (bus.cll && bus.ld) begin
      r_reg <= bus.d;
    end
  end

  always_comb begin
    tc_next = 1'b0;
    if (bus.cll && !bus.ld) begin
      tc_next = underflow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc_reg <= 1'b0;
    end else begin
      tc_reg <= tc_next;
    end
  end

  assign bus.q    = q_bits;
  assign bus.qb   = qb_bits;
  assign bus.zero = zero;
  assign bus.co   = underflow;
  assign bus.tc   = tc_reg;
endmodule

// File: tb/tb_sync_down_counter.sv
// Randomized check of the down-counter against an arithmetic reference model, plus a two-stage cascade.
module tb_sync_down_counter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_down_counter_if #(.WIDTH(W)) a_if ();
  sync_down_counter_if #(.WIDTH(W)) lo_if ();
  sync_down_counter_if #(.WIDTH(W)) hi_if ();

  sync_down_counter #(.WIDTH(W)) u_dut (.clk(clk), .rst(rst), .bus(a_if));
  sync_down_counter #(.WIDTH(W)) u_lo  (.clk(clk), .rst(rst), .bus(lo_if));
  sync_down_counter #(.WIDTH(W)) u_hi  (.clk(clk), .rst(rst), .bus(hi_if));

  // High stage shares control with the low stage and counts on its borrow-out.
  assign hi_if.ci  = lo_if.co;
  assign hi_if.cll = lo_if.cll;
  assign hi_if.ld  = lo_if.ld;
  assign hi_if.rld = lo_if.rld;

  int n_checks = 0;
  int n_pass   = 0;

  int m_q  = 0;
  int m_r  = 0;
  int m_tc = 0;
  localparam int MAXV = (1 << W) - 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    chk("q",    32'(a_if.q),    32'(m_q));
    chk("qb",   32'(a_if.qb),   32'(MAXV - m_q));
    chk("zero", 32'(a_if.zero), 32'(m_q == 0));
    chk("co",   32'(a_if.co),   32'(a_if.ci && m_q == 0));
    chk("tc",   32'(a_if.tc),   32'(m_tc));
  endtask

  // Starts and ends at a negedge; model follows the priority rules directly.
  task automatic step(input logic s_cll, input logic s_ld, input logic [W-1:0] s_d,
                      input logic s_ci, input logic s_rld);
    a_if.cll = s_cll; a_if.ld = s_ld; a_if.d = s_d; a_if.ci = s_ci; a_if.rld = s_rld;
    #1;
    chk("co_pre", 32'(a_if.co), 32'(s_ci && m_q == 0));
    @(posedge clk);
    if (!s_cll) begin
      m_q = 0; m_tc = 0;
    end else if (s_ld) begin
      m_q = int'(s_d); m_r = int'(s_d); m_tc = 0;
    end else if (s_ci) begin
      if (m_q == 0) begin
        m_q = s_rld ? m_r : MAXV; m_tc = 1;
      end else begin
        m_q = m_q - 1; m_tc = 0;
      end
    end else begin
      m_tc = 0;
    end
    @(negedge clk);
    check_outputs();
    $display("step cll=%0b ld=%0b d=%02h ci=%0b rld=%0b -> q=%02h tc=%0b",
             s_cll, s_ld, s_d, s_ci, s_rld, a_if.q, a_if.tc);
  endtask

  task automatic reset_check(input string tag);
    #1;
    chk({tag, "_q"},    32'(a_if.q),    32'h0);
    chk({tag, "_qb"},   32'(a_if.qb),   32'(MAXV));
    chk({tag, "_zero"}, 32'(a_if.zero), 32'h1);
    chk({tag, "_tc"},   32'(a_if.tc),   32'h0);
    chk({tag, "_co"},   32'(a_if.co),   32'(a_if.ci));
    m_q = 0; m_r = 0; m_tc = 0;
  endtask

  initial begin
    logic [W-1:0] rd;
    int cnt16;
    a_if.cll = 1'b1; a_if.ld = 1'b0; a_if.d = '0; a_if.ci = 1'b0; a_if.rld = 1'b0;
    lo_if.cll = 1'b1; lo_if.ld = 1'b0; lo_if.d = '0; lo_if.ci = 1'b0; lo_if.rld = 1'b0;
    hi_if.d = '0;

    // Reset is held across two edges so every flop is known.
    @(negedge clk); @(negedge clk);
    reset_check("rst_init");
    rst = 1'b0;

    // Async reset mid-cycle abandons a loaded count.
    step(1, 1, 8'h5A, 0, 0);
    #2 rst = 1'b1;
    reset_check("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 8'h00, 1, 1);   // R was cleared: underflow reloads 0

    // Load and count through underflow with wrap.
    step(1, 1, 8'h03, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 8'h00, 1, 0);

    // Reload every third cycle.
    step(1, 1, 8'h02, 0, 1);
    for (int i = 0; i < 9; i++) step(1, 0, 8'h00, 1, 1);

    // Clear beats load; later underflow reloads the old R.
    step(1, 1, 8'h07, 0, 0);
    step(0, 1, 8'h44, 0, 1);
    step(1, 0, 8'h00, 1, 1);
    chk("prio_reload", 32'(a_if.q), 32'h07);
    step(1, 1, 8'h10, 1, 0);
    chk("ld_ci", 32'(a_if.q), 32'h10);

    // Gapped enable.
    step(1, 1, 8'h05, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 8'h00, (i % 2) == 0, 0);

    // Zero reload value: tc stays high under continuous enable.
    step(1, 1, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      rd = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 4));
      step($urandom_range(0, 15) != 0, $urandom_range(0, 7) == 0, rd,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end

    // Cascade: 16-bit count from 0x0100 with wrap.
    lo_if.ld = 1'b1; lo_if.d = 8'h00; hi_if.d = 8'h01; lo_if.ci = 1'b0;
    @(negedge clk);
    lo_if.ld = 1'b0; lo_if.ci = 1'b1;
    cnt16 = 16'h0100;
    chk("cas_load", 32'({hi_if.q, lo_if.q}), 32'(cnt16));
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      cnt16 = (cnt16 == 0) ? 16'hFFFF : cnt16 - 1;
      chk("cas_q", 32'({hi_if.q, lo_if.q}), 32'(cnt16));
      chk("cas_hi_ci", 32'(hi_if.ci), 32'((cnt16 & 16'hFF) == 0));
      $display("cascade q=%04h hi_ci=%0b", {hi_if.q, lo_if.q}, hi_if.ci);
    end
    lo_if.ci = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
